cache_mem_responder: RTL

//  Backing-memory responder on the memory side of the cache controller: services line-fill

---
 rtl/cache_mem_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: backing-memory responder for the cache controller.
// Serves line-fill reads and dirty-line writebacks addressed by tag, one
// request at a time, answering each accepted request after LATENCY cycles.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_write/req_tag/req_data request payload (write data ignored for reads)
//   resp_valid/resp_ready      response handshake
//   resp_write/resp_tag        echo of the request being answered
//   resp_data                  read: line contents; write: the data stored
//   busy                       request in flight or response pending
//   rd_count/wr_count          handshaken response counters (MEM_RESP_STATS_EN only)
//
// Build option: define MEM_RESP_STATS_EN to add the saturating response counters.
module cache_mem_responder #(
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned LINE_W  = 32,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [LINE_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_write,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [LINE_W-1:0] resp_data,
`ifdef MEM_RESP_STATS_EN
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
`endif
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << TAG_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                wr_q;
    logic [TAG_W-1:0]    tag_q;
    logic [LINE_W-1:0]   data_q;
    logic                resp_valid_q;
    logic                resp_write_q;
    logic [TAG_W-1:0]    resp_tag_q;
    logic [LINE_W-1:0]   resp_data_q;

    // Each entry holds the XOR of the line with its power-up pattern, so
    // storage that powers up cleared reads back as the pattern. Not reset.
    logic [LINE_W-1:0]   mem_q [DEPTH];

    logic                accept;
    logic                commit;
    logic                resp_hs;
    logic [LINE_W-1:0]   rd_line;

    // Power-up line pattern: the low tag byte replicated across the line.
    function automatic logic [LINE_W-1:0] default_line(input logic [TAG_W-1:0] t);
        return {(LINE_W/8){8'(t)}};
    endfunction

    assign accept  = req_valid && req_ready;
    assign commit  = (state_q == BUSY) && (cnt_q == '0);
    assign resp_hs = resp_valid_q && resp_ready;
    assign rd_line = mem_q[tag_q] ^ default_line(tag_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)         state_d = BUSY;
            BUSY:    if (cnt_q == '0)    state_d = RESP;
            RESP:    if (resp_ready)     state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    req_ready = !rst;
            BUSY:    busy      = 1'b1;
            RESP:    busy      = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // Request capture, latency counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            tag_q        <= '0;
            data_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            if (accept) begin
                wr_q   <= req_write;
                tag_q  <= req_tag;
                data_q <= req_data;
                cnt_q  <= CNT_W'(LATENCY - 1);
            end else if ((state_q == BUSY) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (commit) begin
                resp_valid_q <= 1'b1;
                resp_write_q <= wr_q;
                resp_tag_q   <= tag_q;
                resp_data_q  <= wr_q ? data_q : rd_line;
            end else if (resp_hs) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    // Line storage; a reset landing on the commit edge suppresses the write
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_q) begin
            mem_q[tag_q] <= data_q ^ default_line(tag_q);
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_write = resp_write_q;
    assign resp_tag   = resp_tag_q;
    assign resp_data  = resp_data_q;

`ifdef MEM_RESP_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    // Saturating per-type response counters
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (resp_hs) begin
            if (resp_write_q) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule
